// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage front end for a word-wide data memory.
// Checks alignment, performs loads with lane extraction/extension, and turns
// byte/half stores into read-modify-write cycles. One request in flight at a time.
module load_store_unit #(
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_data,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_write_data,
  output logic        dm_mem_write,
  output logic        dm_mem_read,
  input  logic [31:0] dm_read_data
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP, ERROR
  } state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic        rd_q;
  logic        wr_q;
  logic        bad;
  logic [31:0] eff_addr;

  // Pick the addressed lane out of a memory word and sign/zero-extend it
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [31:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    shifted = word >> {off, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    case (size)
      2'b00:   lane_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   lane_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: lane_extract = word;
    endcase
  endfunction

  // Replace the addressed byte/half lane of a memory word with store data
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size,
                                             input logic [31:0] wdata);
    logic [31:0] mask;
    logic [31:0] data;
    if (size == 2'b00) begin
      mask = 32'h0000_00FF << {off, 3'b000};
      data = {24'd0, wdata[7:0]} << {off, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {off[1], 4'b0000};
      data = {16'd0, wdata[15:0]} << {off[1], 4'b0000};
    end
    lane_merge = (word & ~mask) | data;
  endfunction

  // Alignment check; with errors disabled the low address bits are forced aligned
  always_comb begin
    bad      = 1'b0;
    eff_addr = req_addr;
    case (req_size)
      2'b00: begin
      end
      2'b01: begin
        if (req_addr[0]) begin
          if (ERR_ON_MISALIGN) bad = 1'b1;
          else                 eff_addr[0] = 1'b0;
        end
      end
      2'b10: begin
        if (req_addr[1:0] != 2'b00) begin
          if (ERR_ON_MISALIGN) bad = 1'b1;
          else                 eff_addr[1:0] = 2'b00;
        end
      end
      default: bad = 1'b1;
    endcase
  end

  // Strobes are gated by reset so an in-flight write is dropped on reset
  assign req_ready    = (state == IDLE) & rst_n;
  assign dm_mem_read  = rd_q & rst_n;
  assign dm_mem_write = wr_q & rst_n;

  // Sequencer: every output is registered one state ahead of the cycle it applies to
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_data     <= 32'd0;
      dm_addr       <= 32'd0;
      dm_write_data <= 32'd0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      size_q        <= 2'b00;
      off_q         <= 2'b00;
      uns_q         <= 1'b0;
      wdata_q       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          if (req_valid) begin
            size_q  <= req_size;
            off_q   <= eff_addr[1:0];
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            if (bad) begin
              state      <= ERROR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= 32'd0;
            end else begin
              dm_addr <= {2'b00, eff_addr[31:2]};
              if (!req_store) begin
                state <= LOAD;
                rd_q  <= 1'b1;
              end else if (req_size == 2'b10) begin
                state         <= WRITE;
                wr_q          <= 1'b1;
                dm_write_data <= req_wdata;
              end else begin
                state <= RMW_RD;
                rd_q  <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          resp_data  <= lane_extract(dm_read_data, off_q, size_q, uns_q);
          resp_valid <= 1'b1;
          rd_q       <= 1'b0;
          dm_addr    <= 32'd0;
          state      <= RESP;
        end
        WRITE: begin
          resp_data     <= 32'd0;
          resp_valid    <= 1'b1;
          wr_q          <= 1'b0;
          dm_addr       <= 32'd0;
          dm_write_data <= 32'd0;
          state         <= RESP;
        end
        RMW_RD: begin
          dm_write_data <= lane_merge(dm_read_data, off_q, size_q, wdata_q);
          rd_q          <= 1'b0;
          wr_q          <= 1'b1;
          state         <= RMW_WR;
        end
        RMW_WR: begin
          resp_data     <= 32'd0;
          resp_valid    <= 1'b1;
          wr_q          <= 1'b0;
          dm_addr       <= 32'd0;
          dm_write_data <= 32'd0;
          state         <= RESP;
        end
        default: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
